// File: rtl/sync_debounce.sv
// Per-lane debouncer with registered rise/fall pulses, fed by sync_ff outputs.
// A lane's level changes only after N consecutive en-qualified samples of the new value.
module sync_debounce #(
    parameter int unsigned W     = 1,
    parameter int unsigned N     = 4,
    parameter int unsigned CNT_W = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_sync,
    input  logic         en,
    output logic [W-1:0] level,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    typedef enum logic [1:0] {
        STABLE_LO,
        ARM_HI,
        STABLE_HI,
        ARM_LO
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    for (genvar g = 0; g < W; g++) begin : g_lane
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             level_q, level_d;
        logic             rise_q, rise_d;
        logic             fall_q, fall_d;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            level_d = level_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            if (en) begin
                case (state_q)
                    STABLE_LO: begin
                        if (in_sync[g]) begin
                            if (N == 1) begin
                                state_d = STABLE_HI;
                                level_d = 1'b1;
                                rise_d  = 1'b1;
                            end else begin
                                state_d = ARM_HI;
                                cnt_d   = CNT_ONE;
                            end
                        end
                    end
                    ARM_HI: begin
                        if (!in_sync[g]) begin
                            state_d = STABLE_LO;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_d = STABLE_HI;
                            level_d = 1'b1;
                            rise_d  = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    STABLE_HI: begin
                        if (!in_sync[g]) begin
                            if (N == 1) begin
                                state_d = STABLE_LO;
                                level_d = 1'b0;
                                fall_d  = 1'b1;
                            end else begin
                                state_d = ARM_LO;
                                cnt_d   = CNT_ONE;
                            end
                        end
                    end
                    ARM_LO: begin
                        if (in_sync[g]) begin
                            state_d = STABLE_HI;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_d = STABLE_LO;
                            level_d = 1'b0;
                            fall_d  = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= STABLE_LO;
                cnt_q   <= '0;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        assign level[g] = level_q;
        assign rise[g]  = rise_q;
        assign fall[g]  = fall_q;
    end

endmodule

// File: doc/sync_debounce.md
# sync_debounce

Per-lane debouncer and edge detector in the destination clock domain, directly downstream of the two-flop `sync_ff` synchronizer. It consumes already-synchronized level signals and publishes a filtered level only after the input holds a new value for a programmable number of consecutive sample ticks. It also produces single-cycle rise and fall pulses for downstream control logic, such as interrupt and status capture.

## Interface
- `W`, default 1: number of independent lanes.
- `N`, default 4: consecutive sampled cycles a new value must hold before `level` changes. Legal range 1..65535.
- `CNT_W`, default `$clog2(N+1)`: width of the stability counter. This is a derived parameter and must not be overridden.
- `clk`, input, 1: clock. Same domain as the upstream `sync_ff` output.
- `rst`, input, 1: synchronous reset, active-high.
- `in_sync`, input, W: synchronized input levels, driven by `sync_ff.q`.
- `en`, input, 1: sample tick. The filter only advances in cycles where `en` is 1. Tie `en` high for per-cycle sampling.
- `level`, output, W: debounced level. Registered.
- `rise`, output, W: one-cycle pulse when `level[i]` goes 0→1. Registered.
- `fall`, output, W: one-cycle pulse when `level[i]` goes 1→0. Registered.

## Operation
- Each lane has its own 4-state FSM and its own `CNT_W`-bit counter. Lanes never interact.
- FSM states:
  - `STABLE_LO`: `level` is 0.
  - `ARM_HI`: a candidate high is being counted.
  - `STABLE_HI`: `level` is 1.
  - `ARM_LO`: a candidate low is being counted.
- Transitions occur only in cycles with `en`=1. When `en`=0, state, counter and `level` all hold, and `rise`/`fall` are 0.
- From `STABLE_LO`:
  - `in`=0: stay.
  - `in`=1 and N==1: go to `STABLE_HI`, set `level`=1, pulse `rise`.
  - `in`=1 and N>1: go to `ARM_HI`, set cnt=1.
- From `ARM_HI`:
  - `in`=0: return to `STABLE_LO`, set cnt=0. No pulse.
  - `in`=1 and cnt==N-1: go to `STABLE_HI`, set `level`=1, pulse `rise`, set cnt=0.
  - `in`=1 otherwise: cnt+1.
- `STABLE_HI` and `ARM_LO` mirror the two cases above with polarity inverted, and pulse `fall`.
- A glitch shorter than N sampled cycles never changes `level` and produces no pulse.
- The counter never exceeds N-1, so it cannot wrap.
- At most one of `rise[i]`/`fall[i]` is high in any cycle. Neither is ever high for two consecutive cycles.

## Timing
- Reset values: `level`=0, `rise`=0, `fall`=0, all FSMs in `STABLE_LO`, all counters 0. This is consistent with `sync_ff` resetting to 0.
- Latency, with `en` tied high: `in_sync` high at edges t..t+N-1 gives `level`=1 and `rise`=1 in the cycle after edge t+N-1. That is N cycles after `in_sync` first reads 1, giving N+2 cycles end-to-end from the raw asynchronous input through `sync_ff`.
- Latency with `en` gated: N `en`-qualified samples, not N clocks. Cycles with `en`=0 between samples do not break a run.
- `rise`/`fall` assert in the same cycle that `level` first shows the new value, and deassert the next cycle.
- Reset mid-arm, or while a pulse is high: the next cycle shows reset values. No pulse is generated for the discarded run.
- `rst`=1 and `en`=1 in the same cycle: reset wins.
- `in_sync` is assumed synchronous to `clk`. This block adds no metastability protection of its own.

## Test plan
- Reset: hold `rst` for 3 cycles with `in_sync`=1. Required: `level`/`rise`/`fall`=0 throughout. After release, with N=4 and `en`=1, `rise` fires exactly 4 cycles later.
- Clean edges: N=4, `en`=1, `in_sync` 0→1, held for 10 cycles, then 1→0. Required: `level` rises 4 cycles after the input rises, with a single `rise` pulse. `level` falls 4 cycles after the input falls, with a single `fall` pulse.
- Glitch rejection: N=4, `in_sync` high for 3 cycles then low. Required: `level` stays 0 and no pulses. Repeat the same check from the `STABLE_HI` state for a 3-cycle low glitch.
- Gated sampling: N=3, `en` high every 4th cycle, `in_sync` held high. Required: `rise` in the cycle after the 3rd `en` sample, i.e. about 9 clocks later. `level` is unchanged while `en`=0.
- N=1 and lanes: W=4, N=1, `in_sync`=4'b0101 in one cycle. Required: the next cycle shows `level`=4'b0101, `rise`=4'b0101 and `fall`=0, and lanes 1 and 3 are unaffected.
- Reset mid-arm: N=8, input high for 5 cycles, `rst` pulsed, input still high. Required: the counter restarts, and `rise` fires 8 sampled cycles after `rst` deasserts, not 3.
